traffic_phase_scheduler: RTL
============================

# traffic_phase_scheduler

Sequences the four-approach intersection signal heads. Each green phase is followed by a yellow clearance and an all-red interval. The scheduler picks the next approach round-robin among those with vehicles present, sizes each green from sensor occupancy, ends a green early when its approach empties, and preempts the rotation for an emergency vehicle. It sits between the loop-sensor inputs and the lamp drivers, and all timing runs on an external timebase strobe.

## Interface
- GREEN_SHORT, 30: green duration in ticks when one sensor of the approach is active.
- GREEN_LONG, 60: green duration in ticks when both sensors of the approach are active.
- YELLOW_T, 4: yellow duration in ticks.
- ALLRED_T, 2: all-red duration in ticks.
- CW, 6: timer width. All duration parameters must be ≥1 and fit in CW bits.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous and active-high.
- tick, in, 1: timebase enable. Timers advance only on cycles where tick=1.
- sensors, in, 8: two sensors per approach. Bits [2k-1:2k-2] (0-based) belong to approach k, for k=1..4.
- emerg_req, in, 1: emergency preemption request, level-sensitive.
- emerg_dir, in, 2: preempted approach, where 0..3 maps to approach 1..4.
- green, out, 4: one-hot or zero. Bit k-1 means approach k is green.
- yellow, out, 4: one-hot or zero.
- red, out, 4: equals ~(green|yellow).
- active_dir, out, 2: approach currently or most recently served.
- phase_done, out, 1: one-cycle pulse when a yellow ends.

## Operation
- States: ALL_RED, GREEN, YELLOW, PREEMPT.
- Registers: state, timer (CW bits), cur (2 bits), last (2 bits), pre (flag).
- Reset values: state=ALL_RED, timer=ALLRED_T, cur=0, last=3, green=0, yellow=0, red=4'b1111, active_dir=0, phase_done=0.
- req[k] = OR of the two sensors of approach k. both[k] = AND of the two sensors.
- Timed states (ALL_RED, GREEN, YELLOW) follow one rule. On a tick cycle with timer==1, the state exits at that edge. On a tick cycle with timer>1, timer decrements. So each timed state lasts exactly its duration in ticks.
- ALL_RED expiry, in priority order:
  - If emerg_req=1, go to PREEMPT with cur=emerg_dir.
  - Otherwise, if any req is set, the winner is the first requesting approach searching from last+1 upward, modulo 4. Go to GREEN with cur=winner and timer=GREEN_LONG if both[cur], else GREEN_SHORT.
  - Otherwise, stay in ALL_RED with timer held at 1 and re-evaluate every tick. No lamps light.
- GREEN, in priority order:
  - If emerg_req=1 and emerg_dir==cur, go to PREEMPT, keeping the green lit.
  - If emerg_req=1 and emerg_dir!=cur, go to YELLOW.
  - Gap-out: if req[cur]=0 on a tick cycle and some other req is set, go to YELLOW.
  - On expiry, go to YELLOW.
- Every entry into YELLOW loads timer=YELLOW_T and sets last=cur.
- Green duration is sampled at entry only. Later sensor changes do not resize the green.
- YELLOW expiry: go to ALL_RED with timer=ALLRED_T, and phase_done=1 for exactly that cycle. Emergency requests do not shorten YELLOW or ALL_RED.
- PREEMPT:
  - green[cur]=1 and no timer runs.
  - emerg_dir is latched at entry. Changes to emerg_dir are ignored while in PREEMPT.
  - On emerg_req=0, go to YELLOW for cur, then resume normal rotation from last=cur.
- Outputs:
  - green[cur] is set in GREEN or PREEMPT.
  - yellow[cur] is set in YELLOW.
  - active_dir=cur.
  - Outputs are decoded from registered state only, with no combinational path from inputs.

## Timing
- A state change is visible on outputs in the cycle after the decision edge, with zero added latency beyond the register.
- tick=0 freezes every timer. Non-timer transitions still occur on any cycle: preemption entry/exit and the GREEN→YELLOW emergency abort.
- Gap-out is evaluated only on tick cycles.
- If gap-out and expiry coincide, the result is a single transition to YELLOW.
- rst=1 in any state returns all registers to their reset values at the next edge, including mid-PREEMPT and mid-YELLOW. Lamps are all red in the following cycle.
- The round-robin pointer only advances on YELLOW entry. An approach that gaps out still counts as served.

## Test plan
Bench setup: GREEN_SHORT=3, GREEN_LONG=6, YELLOW_T=2, ALLRED_T=1, tick=1 constantly.
- Idle: after reset with sensors=0 for 20 cycles, red=4'b1111, green=0, phase_done=0 throughout.
- Long green: sensors=8'h03 → green=4'b0001 for 6 cycles, then yellow=4'b0001 for 2 cycles, then phase_done pulses, then red 1 cycle, then green=4'b0001 again.
- Round robin: sensors=8'h55 → greens 0001, 0010, 0100, 1000, 0001. Each green lasts 3 cycles and each is separated by 2 yellow + 1 all-red cycles.
- Gap-out: sensors=8'h03 until 2 cycles into green, then 8'h30 → yellow=0001 on the next cycle, then green=4'b0100.
- Preemption: in green on approach 1, assert emerg_req with emerg_dir=2 for 10 cycles → yellow 0001 for 2 cycles, all-red 1 cycle, green=4'b0100 held until deassert, then yellow 0100. Asserting with emerg_dir=0 during green 0001 instead holds 0001 with no yellow.
- Reset mid-phase: rst=1 for 1 cycle during PREEMPT → red=4'b1111 and active_dir=0 next cycle. The first green after reset goes to approach 1.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: four-approach signal sequencer with round-robin, gap-out and emergency preemption
//   clk, rst        : clock, synchronous active-high reset
//   tick            : timebase strobe; timers advance only when high
//   sensors[7:0]    : two loop sensors per approach, bits [2k+1:2k] for approach k+1
//   emerg_req/dir   : level-sensitive preemption request and target approach (0..3)
//   green/yellow    : one-hot-or-zero lamp drives; red = ~(green|yellow)
//   active_dir      : approach currently or most recently served
//   phase_done      : one-cycle pulse on the cycle after a yellow ends
module traffic_phase_scheduler #(
    parameter int GREEN_SHORT = 30,
    parameter int GREEN_LONG  = 60,
    parameter int YELLOW_T    = 4,
    parameter int ALLRED_T    = 2,
    parameter int CW          = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] sensors,
    input  logic       emerg_req,
    input  logic [1:0] emerg_dir,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [1:0] active_dir,
    output logic       phase_done
);
    typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_PREEMPT} state_t;

    localparam logic [CW-1:0] L_GS = CW'(GREEN_SHORT);
    localparam logic [CW-1:0] L_GL = CW'(GREEN_LONG);
    localparam logic [CW-1:0] L_Y  = CW'(YELLOW_T);
    localparam logic [CW-1:0] L_AR = CW'(ALLRED_T);
    localparam logic [CW-1:0] L_1  = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_timer;
    logic [1:0]    r_cur;
    logic [1:0]    r_last;
    logic          r_pd;

    logic [3:0] w_req;
    logic [3:0] w_both;
    logic [1:0] w_win;
    logic [3:0] w_cur_oh;
    logic       w_gap;
    logic       w_exp;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_req[k]  = |sensors[2*k +: 2];
            w_both[k] = &sensors[2*k +: 2];
        end
    end

    // Descending scan so the closest requester after r_last wins; i=4 wraps to r_last itself.
    always_comb begin
        w_win = r_last;
        for (int i = 4; i >= 1; i--)
            if (w_req[r_last + 2'(i)]) w_win = r_last + 2'(i);
    end

    assign w_cur_oh = 4'b0001 << r_cur;
    // Gap-out needs another approach waiting, otherwise the green simply runs to expiry.
    assign w_gap    = tick && !w_req[r_cur] && |(w_req & ~w_cur_oh);
    assign w_exp    = tick && r_timer == L_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ALL_RED;
            r_timer <= L_AR;
            r_cur   <= 2'd0;
            r_last  <= 2'd3;
            r_pd    <= 1'b0;
        end else begin
            r_pd <= 1'b0;
            case (r_state)
                S_ALL_RED: begin
                    if (tick) begin
                        if (r_timer != L_1) begin
                            r_timer <= r_timer - L_1;
                        end else if (emerg_req) begin
                            r_state <= S_PREEMPT;
                            r_cur   <= emerg_dir;
                        end else if (|w_req) begin
                            r_state <= S_GREEN;
                            r_cur   <= w_win;
                            r_timer <= w_both[w_win] ? L_GL : L_GS;
                        end
                    end
                end
                S_GREEN: begin
                    if (emerg_req && emerg_dir == r_cur) begin
                        r_state <= S_PREEMPT;
                    end else if (emerg_req || w_gap || w_exp) begin
                        r_state <= S_YELLOW;
                        r_timer <= L_Y;
                        r_last  <= r_cur;
                    end else if (tick) begin
                        r_timer <= r_timer - L_1;
                    end
                end
                S_YELLOW: begin
                    if (tick) begin
                        if (r_timer == L_1) begin
                            r_state <= S_ALL_RED;
                            r_timer <= L_AR;
                            r_pd    <= 1'b1;
                        end else begin
                            r_timer <= r_timer - L_1;
                        end
                    end
                end
                S_PREEMPT: begin
                    // r_cur was captured on entry, so emerg_dir is ignored here.
                    if (!emerg_req) begin
                        r_state <= S_YELLOW;
                        r_timer <= L_Y;
                        r_last  <= r_cur;
                    end
                end
                default: r_state <= S_ALL_RED;
            endcase
        end
    end

    assign green      = (r_state == S_GREEN || r_state == S_PREEMPT) ? w_cur_oh : 4'b0000;
    assign yellow     = (r_state == S_YELLOW) ? w_cur_oh : 4'b0000;
    assign red        = ~(green | yellow);
    assign active_dir = r_cur;
    assign phase_done = r_pd;
endmodule
